// File: rtl/systolic_pkg.sv
// systolic_pkg: shared lane widths, lane count and lane-pack order for the systolic output path.
package systolic_pkg;
    localparam int WIDTH = 16;
    localparam int FRAC_BIT = 10;
    localparam int LANES = 4;
    localparam int PACK_W = LANES * WIDTH;
    // Lane k occupies packed bits [k*WIDTH +: WIDTH], so y0 lands in the LSBs.
    typedef enum logic [1:0] {LANE_Y0, LANE_Y1, LANE_Y2, LANE_Y3} lane_e;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word fall-through FIFO; head entry is on dout whenever not empty, zero otherwise.
module sync_fifo_fwft #(
    parameter int DATA_W = 64,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W-1:0]            dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic push_ok, pop_ok;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign pop_ok = pop & ~clr & ~empty;
    assign push_ok = push & ~clr & (~full | pop_ok);
    assign dout = empty ? '0 : mem[rptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok) rptr <= rptr + AW'(1);
            if (push_ok != pop_ok) count <= push_ok ? count + CW'(1) : count - CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end
endmodule

// File: rtl/systolic_out_collector.sv
// systolic_out_collector: buffers systolic result rows into an AXI-Stream master with framing and flow control.
// Optional SYSTOLIC_OUT_RELU_EN rectifies negative lanes at push time.
module systolic_out_collector
    import systolic_pkg::*;
#(
    parameter int WIDTH = systolic_pkg::WIDTH,
    parameter int FRAC_BIT = systolic_pkg::FRAC_BIT,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         y0,
    input  logic [WIDTH-1:0]         y1,
    input  logic [WIDTH-1:0]         y2,
    input  logic [WIDTH-1:0]         y3,
    input  logic                     out_valid,
    output logic                     array_en,
    input  logic [7:0]               frame_len,
    output logic [LANES*WIDTH-1:0]   m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    if (FRAC_BIT >= WIDTH || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("systolic_out_collector: invalid WIDTH/FRAC_BIT/DEPTH");
    end
    logic [WIDTH-1:0] lane [LANES];
    logic [LANES*WIDTH-1:0] din;
    logic [CW-1:0] count;
    logic [7:0] row_cnt, last_idx;
    logic full, empty, pop, drop;
    assign lane[LANE_Y0] = y0;
    assign lane[LANE_Y1] = y1;
    assign lane[LANE_Y2] = y2;
    assign lane[LANE_Y3] = y3;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef SYSTOLIC_OUT_RELU_EN
        assign din[i*WIDTH +: WIDTH] = lane[i][WIDTH-1] ? '0 : lane[i];
`else
        assign din[i*WIDTH +: WIDTH] = lane[i];
`endif
    end
    sync_fifo_fwft #(.DATA_W(LANES*WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (out_valid),
        .pop   (pop),
        .din   (din),
        .dout  (m_axis_tdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign m_axis_tvalid = ~empty;
    assign pop = m_axis_tvalid & m_axis_tready;
    assign drop = out_valid & full & ~pop & ~clr;
    // Two entries of headroom absorb rows already in flight in the array pipeline.
    assign array_en = count < CW'(DEPTH - 2);
    assign last_idx = (frame_len == 8'd0) ? 8'd0 : frame_len - 8'd1;
    assign m_axis_tlast = m_axis_tvalid & (row_cnt == last_idx);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            row_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (pop) row_cnt <= m_axis_tlast ? 8'd0 : row_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_systolic_out_collector.sv
// tb_systolic_out_collector: directed self-checking bench for systolic_out_collector (DEPTH=8, WIDTH=16).
module tb_systolic_out_collector;
    localparam int W = 16;
    localparam int D = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic out_valid = 1'b0;
    logic m_axis_tready = 1'b0;
    logic [W-1:0] y0 = '0, y1 = '0, y2 = '0, y3 = '0;
    logic [7:0] frame_len = 8'd1;
    logic array_en, m_axis_tvalid, m_axis_tlast, overflow;
    logic [4*W-1:0] m_axis_tdata;
    int vectors = 0;
    int errors = 0;

    systolic_out_collector #(.WIDTH(W), .FRAC_BIT(10), .DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .y0            (y0),
        .y1            (y1),
        .y2            (y2),
        .y3            (y3),
        .out_valid     (out_valid),
        .array_en      (array_en),
        .frame_len     (frame_len),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] row_of(input int k);
        logic [15:0] b;
        b = 16'(k * 16);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    task automatic set_row(input logic [63:0] r);
        {y3, y2, y1, y0} = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        vectors++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        vectors++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        vectors++; if (array_en !== 1'b1) begin errors++; $display("FAIL reset_array_en got %b want 1", array_en); end
        step();
        rst = 1'b0;
        step();
        vectors++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_tvalid got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_single();
        logic [63:0] exp;
`ifdef SYSTOLIC_OUT_RELU_EN
        exp = 64'h0400_2800_0000_0800;
`else
        exp = 64'h0400_2800_F800_0800;
`endif
        frame_len = 8'd1;
        m_axis_tready = 1'b1;
        set_row(64'h0400_2800_F800_0800);
        out_valid = 1'b1;
        step();
        out_valid = 1'b0;
        vectors++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid got %b want 1", m_axis_tvalid); end
        vectors++; if (m_axis_tdata !== exp) begin errors++; $display("FAIL single_tdata got %h want %h", m_axis_tdata, exp); end
        vectors++; if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL single_tlast got %b want 1", m_axis_tlast); end
        step();
        vectors++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_tvalid_after got %b want 0", m_axis_tvalid); end
        vectors++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL single_tdata_after got %h want 0", m_axis_tdata); end
    endtask

    task automatic test_frame();
        frame_len = 8'd3;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_row(row_of(i));
            out_valid = 1'b1;
            step();
            vectors++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL frame_tvalid beat %0d got %b want 1", i, m_axis_tvalid); end
            vectors++; if (m_axis_tdata !== row_of(i)) begin errors++; $display("FAIL frame_tdata beat %0d got %h want %h", i, m_axis_tdata, row_of(i)); end
            vectors++; if (m_axis_tlast !== (i == 2)) begin errors++; $display("FAIL frame_tlast beat %0d got %b want %b", i, m_axis_tlast, i == 2); end
        end
        out_valid = 1'b0;
        step();
        vectors++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL frame_drained got %b want 0", m_axis_tvalid); end
        frame_len = 8'd0;
        for (int i = 3; i < 5; i++) begin
            set_row(row_of(i));
            out_valid = 1'b1;
            step();
            vectors++; if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL frame_len0_tlast beat %0d got %b want 1", i, m_axis_tlast); end
        end
        out_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        frame_len = 8'd8;
        m_axis_tready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            set_row(row_of(10 + k));
            out_valid = 1'b1;
            step();
            vectors++; if (array_en !== (k + 1 < D - 2)) begin errors++; $display("FAIL bp_array_en row %0d got %b want %b", k, array_en, k + 1 < D - 2); end
            vectors++; if (overflow !== (k == 8)) begin errors++; $display("FAIL bp_overflow row %0d got %b want %b", k, overflow, k == 8); end
            vectors++; if (m_axis_tdata !== row_of(10)) begin errors++; $display("FAIL bp_stall_tdata row %0d got %h want %h", k, m_axis_tdata, row_of(10)); end
        end
        out_valid = 1'b0;
        m_axis_tready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            vectors++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_drain_tvalid beat %0d got %b want 1", j, m_axis_tvalid); end
            vectors++; if (m_axis_tdata !== row_of(10 + j)) begin errors++; $display("FAIL bp_drain_tdata beat %0d got %h want %h", j, m_axis_tdata, row_of(10 + j)); end
            vectors++; if (m_axis_tlast !== (j == 7)) begin errors++; $display("FAIL bp_drain_tlast beat %0d got %b want %b", j, m_axis_tlast, j == 7); end
            step();
        end
        vectors++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", m_axis_tvalid); end
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky got %b want 1", overflow); end
    endtask

    task automatic test_clr();
        m_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_row(row_of(20 + k));
            out_valid = 1'b1;
            step();
        end
        clr = 1'b1;
        m_axis_tready = 1'b1;
        set_row(row_of(25));
        step();
        clr = 1'b0;
        out_valid = 1'b0;
        m_axis_tready = 1'b0;
        vectors++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL clr_tvalid got %b want 0", m_axis_tvalid); end
        vectors++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL clr_tdata got %h want 0", m_axis_tdata); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b want 0", overflow); end
        vectors++; if (array_en !== 1'b1) begin errors++; $display("FAIL clr_array_en got %b want 1", array_en); end
        step();
        vectors++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL clr_push_ignored got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_full_pop();
        m_axis_tready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_row(row_of(30 + k));
            out_valid = 1'b1;
            step();
        end
        vectors++; if (array_en !== 1'b0) begin errors++; $display("FAIL fp_full_array_en got %b want 0", array_en); end
        set_row(row_of(38));
        m_axis_tready = 1'b1;
        step();
        out_valid = 1'b0;
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow got %b want 0", overflow); end
        vectors++; if (array_en !== 1'b0) begin errors++; $display("FAIL fp_still_full got %b want 0", array_en); end
        for (int j = 1; j < 9; j++) begin
            vectors++; if (m_axis_tdata !== row_of(30 + j)) begin errors++; $display("FAIL fp_drain_tdata beat %0d got %h want %h", j, m_axis_tdata, row_of(30 + j)); end
            step();
        end
        vectors++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL fp_empty got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_async_reset();
        frame_len = 8'd3;
        m_axis_tready = 1'b1;
        set_row(row_of(40));
        out_valid = 1'b1;
        step();
        set_row(row_of(41));
        step();
        out_valid = 1'b0;
        m_axis_tready = 1'b0;
        vectors++; if (m_axis_tdata !== row_of(41)) begin errors++; $display("FAIL ar_midframe_tdata got %h want %h", m_axis_tdata, row_of(41)); end
        #3;
        rst = 1'b1;
        #1;
        vectors++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ar_tvalid got %b want 0", m_axis_tvalid); end
        vectors++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL ar_tdata got %h want 0", m_axis_tdata); end
        vectors++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL ar_tlast got %b want 0", m_axis_tlast); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_overflow got %b want 0", overflow); end
        vectors++; if (array_en !== 1'b1) begin errors++; $display("FAIL ar_array_en got %b want 1", array_en); end
        #2;
        rst = 1'b0;
        step();
        vectors++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ar_resume_empty got %b want 0", m_axis_tvalid); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_resume_overflow got %b want 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_backpressure();
        test_clr();
        test_full_pop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
